// File: rtl/ir_queue_pkg.sv
// rtl/ir_queue_pkg.sv - shared instruction-word sizing for the IR queue and decode
//
// Purpose: default instruction word width and the upper/lower half split
//          used by the write-upper path and by decode.
// Contents: IR_WIDTH, IR_HALF, half_of()
package ir_queue_pkg;

  localparam int IR_WIDTH = 16;
  localparam int IR_HALF  = IR_WIDTH / 2;

  // Split point of an instruction word: bits [w-1:w/2] are the upper half.
  function automatic int half_of(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/ir_queue_ctrl.sv
// rtl/ir_queue_ctrl.sv - pointer, occupancy and overflow control for the IR queue
//
// Purpose: owns rd/wr pointers, entry count and the sticky overflow flag, and
//          decides which storage updates are accepted each cycle.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_write, i_writeu     push / patch-upper requests
//   i_pop, i_flush        consume head / discard everything
//   o_rd_ptr, o_wr_ptr    head and next-free entry indices
//   o_wu_ptr              index of the newest entry (write-upper target)
//   o_push, o_patch       accepted push / accepted write-upper this cycle
//   o_count, o_valid      occupancy and count != 0
//   o_full, o_ovf         count == DEPTH, sticky dropped-write flag
module ir_queue_ctrl
  import ir_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_write,
  input  logic          i_writeu,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [PW-1:0] o_rd_ptr,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_wu_ptr,
  output logic          o_push,
  output logic          o_patch,
  output logic [CW-1:0] o_count,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_ovf
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_patch_ok;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Flush overrides every other request, so all acceptances are gated by it.
  assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
  // A full queue still accepts a write when a pop frees the head this cycle.
  assign w_push_ok = i_write & (~w_full | w_pop_ok) & ~i_flush;
  assign w_drop    = i_write & w_full & ~w_pop_ok & ~i_flush;
  // Write-upper loses to write (even a dropped one) and is meaningless when
  // the only entry is being popped away.
  assign w_patch_ok = i_writeu & ~i_write & ~w_empty & ~i_flush
                    & ~((r_count == ONE_CNT) & w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + ONE_CNT;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - ONE_CNT;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_wu_ptr = r_wr_ptr - PW'(1);
  assign o_push   = w_push_ok;
  assign o_patch  = w_patch_ok;
  assign o_count  = r_count;
  assign o_valid  = ~w_empty;
  assign o_full   = w_full;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - FIFO instruction register queue with write-upper patching
//
// Purpose: holds up to DEPTH fetched instruction words and presents the oldest
//          to decode; writeu patches the upper half of the newest entry.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   din           write data (writeu uses din[H-1:0])
//   write         push din as a new entry
//   writeu        replace upper half of newest entry with din[H-1:0]
//   pop           consume head entry
//   flush         discard all entries
//   dout          head entry, 0 when empty
//   valid, full   count != 0, count == DEPTH
//   count         stored entries
//   ovf           sticky: a write was dropped on a full queue
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       write,
  input  logic                       writeu,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int H  = half_of(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_wu_ptr;
  logic          w_push;
  logic          w_patch;
  logic [CW-1:0] w_count;
  logic          w_valid;
  logic          w_full;
  logic          w_ovf;

  ir_queue_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_write  (write),
    .i_writeu (writeu),
    .i_pop    (pop),
    .i_flush  (flush),
    .o_rd_ptr (w_rd_ptr),
    .o_wr_ptr (w_wr_ptr),
    .o_wu_ptr (w_wu_ptr),
    .o_push   (w_push),
    .o_patch  (w_patch),
    .o_count  (w_count),
    .o_valid  (w_valid),
    .o_full   (w_full),
    .o_ovf    (w_ovf)
  );

  // Push and patch are mutually exclusive (write wins), so at most one entry
  // changes per cycle. Flush leaves storage intact; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= din;
    end else if (w_patch) begin
      r_mem[w_wu_ptr][WIDTH-1:H] <= din[H-1:0];
    end
  end

  assign dout  = w_valid ? r_mem[w_rd_ptr] : '0;
  assign valid = w_valid;
  assign full  = w_full;
  assign count = w_count;
  assign ovf   = w_ovf;

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - self-checking scoreboard bench for ir_queue
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        write = 1'b0;
  logic        writeu = 1'b0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dout;
  logic        valid;
  logic        full;
  logic [2:0]  count;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected queue contents, oldest first.
  logic [15:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  logic        popped;
  logic [15:0] pop_exp;
  logic [15:0] pop_got;

  always #5 clk = ~clk;

  ir_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .write  (write),
    .writeu (writeu),
    .pop    (pop),
    .flush  (flush),
    .dout   (dout),
    .valid  (valid),
    .full   (full),
    .count  (count),
    .ovf    (ovf)
  );

  // Drive one cycle of stimulus and advance the scoreboard model.
  task automatic step(input logic r, input logic f, input logic w,
                      input logic wu, input logic p, input logic [15:0] d);
    logic pop_ok, wr_ok, wu_ok, is_full;
    logic [15:0] tmp;
    @(negedge clk);
    rst = r; flush = f; write = w; writeu = wu; pop = p; din = d;
    #1;
    pop_got = dout;
    popped  = 1'b0;
    if (r || f) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      is_full = (exp_q.size() == 4);
      pop_ok  = p && (exp_q.size() > 0);
      wr_ok   = w && (!is_full || pop_ok);
      wu_ok   = wu && !w && (exp_q.size() > 0) && !(exp_q.size() == 1 && pop_ok);
      if (w && is_full && !pop_ok) exp_ovf = 1'b1;
      if (wu_ok) begin
        tmp = exp_q[exp_q.size()-1];
        tmp[15:8] = d[7:0];
        exp_q[exp_q.size()-1] = tmp;
      end
      if (pop_ok) begin
        pop_exp = exp_q.pop_front();
        popped  = 1'b1;
      end
      if (wr_ok) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    rst = 0; flush = 0; write = 0; writeu = 0; pop = 0; din = '0;
  endtask

  function automatic logic [15:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
  endfunction

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 16'h0);
    checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_writeu();
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0F0F);
    checks++; if (dout !== 16'h0F0F) begin failures++; $display("FAIL wu_first got=%h exp=0f0f", dout); end
    step(0, 0, 0, 1, 0, 16'h0003);
    checks++; if (dout !== 16'h030F || dout !== exp_head()) begin failures++; $display("FAIL wu_patch got=%h exp=030f", dout); end
    checks++; if (count !== 3'd1 || valid !== 1'b1) begin failures++; $display("FAIL wu_count got=%0d/%b exp=1/1", count, valid); end
  endtask

  task automatic test_fill_ovf();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, words[i]);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/4", full, count); end
    step(0, 0, 1, 0, 0, 16'h5555);
    checks++; if (ovf !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL fill_ovf got=%b/%0d exp=1/4", ovf, count); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (!popped || pop_got !== pop_exp || pop_got !== words[i]) begin
        failures++; $display("FAIL fill_pop%0d got=%h exp=%h", i, pop_got, words[i]);
      end
    end
    checks++; if (dout !== 16'h0 || valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%h/%b exp=0000/0", dout, valid); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fill_ovf_sticky got=%b exp=1", ovf); end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 16'h1111 * (i + 1));
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 1, 16'hA000 + 16'(i));
      checks++;
      if (pop_got !== pop_exp || count !== 3'd4 || ovf !== 1'b0 || dout !== exp_head()) begin
        failures++; $display("FAIL b2b_%0d got=%h/%0d/%b/%h exp=%h/4/0/%h", i, pop_got, count, ovf, dout, pop_exp, exp_head());
      end
    end
    checks++; if (dout !== 16'hA002) begin failures++; $display("FAIL b2b_wrap_head got=%h exp=a002", dout); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 16'h0);
      checks++;
      if (pop_got !== pop_exp || pop_got !== 16'hA002 + 16'(i)) begin
        failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, pop_got, 16'hA002 + 16'(i));
      end
    end
  endtask

  task automatic test_empty_write_pop();
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 1, 16'h1234);
    checks++; if (count !== 3'd1 || dout !== 16'h1234) begin failures++; $display("FAIL ewp got=%0d/%h exp=1/1234", count, dout); end
  endtask

  task automatic test_writeu_pop();
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h00FF);
    step(0, 0, 0, 1, 1, 16'h0012);
    checks++; if (count !== 3'd0 || dout !== 16'h0) begin failures++; $display("FAIL wup1 got=%0d/%h exp=0/0000", count, dout); end
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h00FF);
    step(0, 0, 1, 0, 0, 16'h0034);
    step(0, 0, 0, 1, 1, 16'h0012);
    checks++; if (count !== 3'd1 || dout !== 16'h1234 || dout !== exp_head()) begin failures++; $display("FAIL wup2 got=%0d/%h exp=1/1234", count, dout); end
  endtask

  task automatic test_flush_rst();
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 16'h0100 + 16'(i));
    step(0, 0, 0, 0, 1, 16'h0);
    checks++; if (count !== 3'd3 || ovf !== 1'b1) begin failures++; $display("FAIL fl_setup got=%0d/%b exp=3/1", count, ovf); end
    step(0, 1, 1, 0, 0, 16'h7777);
    checks++; if (count !== 3'd0 || valid !== 1'b0 || ovf !== 1'b0 || dout !== 16'h0) begin
      failures++; $display("FAIL flush got=%0d/%b/%b/%h exp=0/0/0/0000", count, valid, ovf, dout);
    end
    step(0, 0, 1, 0, 0, 16'h8888);
    step(0, 0, 1, 0, 0, 16'h9999);
    step(1, 0, 0, 0, 0, 16'h0);
    checks++; if (count !== 3'd0 || valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0 || dout !== 16'h0) begin
      failures++; $display("FAIL rst_mid got=%0d/%b/%b/%b/%h exp=all zero", count, valid, full, ovf, dout);
    end
  endtask

  task automatic test_random();
    logic f, w, wu, p;
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 300; i++) begin
      f  = ($urandom_range(0, 19) == 0);
      w  = ($urandom_range(0, 1) == 1);
      wu = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 1) == 1);
      step(0, f, w, wu, p, 16'($urandom));
      checks++;
      if (dout !== exp_head() || count !== 3'(exp_q.size()) || ovf !== exp_ovf
          || valid !== (exp_q.size() != 0) || full !== (exp_q.size() == 4)
          || (popped && pop_got !== pop_exp)) begin
        failures++;
        $display("FAIL rand_%0d got=%h/%0d/%b exp=%h/%0d/%b", i, dout, count, ovf, exp_head(), exp_q.size(), exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_writeu();
    test_fill_ovf();
    test_back_to_back();
    test_empty_write_pop();
    test_writeu_pop();
    test_flush_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register queue: successor to the single-entry instruction register.
- Holds up to DEPTH fetched instruction words in FIFO order and presents the oldest to decode.
- Keeps the write-upper operation: patches the upper half of the newest entry, for immediate/extension loads.
- Adds consumer pop, flush for branches, occupancy count and a sticky overflow flag.

Parameters:
WIDTH, 16, instruction word width; even, >= 4; H = WIDTH/2.
DEPTH, 4, queue entries; power of 2, >= 2.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  write data.
write  input  1  push din as a new entry.
writeu  input  1  replace upper half of newest entry with din[H-1:0].
pop  input  1  consume head entry.
flush  input  1  discard all entries (branch/redirect).
dout  output  WIDTH  head entry; 0 when empty.
valid  output  1  count != 0.
full  output  1  count == DEPTH.
count  output  $clog2(DEPTH+1)  number of stored entries.
ovf  output  1  sticky: a write was dropped because the queue was full.

Behaviour:
- Reset (rst=1 at edge): rd_ptr, wr_ptr, count, ovf = 0; all storage entries = 0. Outputs after reset: dout=0, valid=0, full=0, count=0, ovf=0.
- Priority per edge: rst > flush > {write, pop, writeu}.
- flush: pointers and count to 0, ovf to 0. Storage is not cleared. Any same-cycle write, pop or writeu is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- write:
  - If not full, or full with an accepted pop in the same cycle: mem[wr_ptr] <= din and wr_ptr++.
  - If full without pop: data dropped, ovf <= 1, nothing else changes.
- pop:
  - If count > 0: rd_ptr++.
  - If empty: ignored. No bypass, so write+pop on an empty queue stores the word and pops nothing.
- count update: +1 on accepted write only, -1 on accepted pop only, unchanged when both or neither.
- writeu:
  - Target entry is mem[wr_ptr-1] (mod DEPTH), the most recently pushed word.
  - Action: target[WIDTH-1:H] <= din[H-1:0]; lower half unchanged.
  - Ignored when count == 0.
  - Ignored when write is asserted the same cycle (write wins).
  - Ignored when an accepted pop removes the last entry the same cycle (count==1 && pop).
  - Allowed when a pop of a different entry occurs the same cycle.
- Read path:
  - dout = valid ? mem[rd_ptr] : 0, combinational from registered storage.
  - Latency: a word written at edge N is visible on dout after edge N if the queue was empty.
  - writeu to the head entry is visible on dout after that edge.
- valid, full and count are combinational decodes of registered count; no glitches on inputs.
- ovf stays set until rst or flush; pop does not clear it.

Decomposition:
- Shared package/header: default instruction WIDTH (16) and the H = WIDTH/2 split constant, reused by decode.
- No typedefs needed.
- One natural sub-module, ir_queue_ctrl: pointers, count, full/valid/ovf.
- ir_queue owns the storage array, the write-upper merge and the read mux.

Test Plan:
- rst, then write din=0x0F0F, then writeu din=0x0003 -> dout=0x0F0F after first edge, 0x030F after second; count=1, valid=1.
- Push 0x1111, 0x2222, 0x3333, 0x4444 -> full=1, count=4. Push 0x5555 -> ovf=1, count stays 4. Pop 4 times -> dout sequence 0x1111..0x4444, then dout=0, valid=0.
- Full queue: write 0xAAAA + pop same edge -> count stays 4, dout=0x2222, no ovf. Repeat until pointer wrap; FIFO order is preserved across the wrap.
- Empty queue: write 0x1234 + pop same edge -> count=1, dout=0x1234.
- count=1 holding 0x00FF: writeu din=0x0012 + pop -> count=0, writeu discarded. Same case with count=2 -> newest entry's upper half becomes 0x12.
- 3 entries with ovf=1: flush + write 0x7777 same edge -> count=0, valid=0, ovf=0, dout=0. rst mid-fill -> all outputs 0 after the edge.
